// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the ALU-borrowing multiply sequencer: the ALU control
// encodings, flag bit positions and the sequencer state encoding.
package alu_mul_seq_pkg;

   // ALU op_type encodings
   localparam logic [1:0] ALU_ARITH = 2'b00;
   localparam logic [1:0] ALU_LOGIC = 2'b01;
   localparam logic [1:0] ALU_SHIFT = 2'b10;
   localparam logic [1:0] ALU_MOVE  = 2'b11;

   // ALU shift_sel[1:0] encodings; shift_sel[2] selects "through carry"
   localparam logic [1:0] SHIFT_SHL = 2'b00;
   localparam logic [1:0] SHIFT_SHR = 2'b01;
   localparam logic [1:0] SHIFT_ROL = 2'b10;
   localparam logic [1:0] SHIFT_ROR = 2'b11;

   // ALU logic_sel encodings
   localparam logic [1:0] LOGIC_AND = 2'b00;
   localparam logic [1:0] LOGIC_OR  = 2'b01;
   localparam logic [1:0] LOGIC_XOR = 2'b10;
   localparam logic [1:0] LOGIC_NOT = 2'b11;

   // Bit positions inside the 4-bit flag vector {V,N,C,Z}
   localparam int Z_FLAG = 0;
   localparam int C_FLAG = 1;
   localparam int N_FLAG = 2;
   localparam int V_FLAG = 3;

   // Multiply sequencer states
   typedef enum logic [2:0] {
      MUL_IDLE    = 3'd0,
      MUL_ADD     = 3'd1,
      MUL_SHH     = 3'd2,
      MUL_SHL     = 3'd3,
      MUL_RESTORE = 3'd4
   } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add 8x8 unsigned multiplier that drives the shared ALU one operation
// per clock, keeps the partial product locally and restores the CPU flags
// on completion so the multiply leaves Z/C/N/V untouched.
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   mul_a,
   input  logic [WIDTH-1:0]   mul_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [1:0]         alu_op_type,
   output logic [1:0]         alu_arith_sel,
   output logic [1:0]         alu_logic_sel,
   output logic [3:0]         alu_shift_sel,
   output logic [WIDTH-1:0]   alu_operand1,
   output logic [WIDTH-1:0]   alu_operand2,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic               alu_flag_z,
   input  logic               alu_flag_c,
   input  logic               alu_flag_n,
   input  logic               alu_flag_v,
   output logic [3:0]         alu_flag_din,
   output logic               alu_flag_wr
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mul_state_t           state;
   mul_state_t           state_next;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     ph;
   logic [WIDTH-1:0]     pl;
   logic [CNT_W-1:0]     cnt;
   logic [3:0]           saved;
   logic                 from_add;
   logic [2*WIDTH-1:0]   product_r;
   logic                 done_r;

   assign product = product_r;
   assign done    = done_r;

   // State register plus partial-product datapath, advanced by ALU results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= MUL_IDLE;
         mcand     <= '0;
         ph        <= '0;
         pl        <= '0;
         cnt       <= '0;
         saved     <= '0;
         from_add  <= 1'b0;
         product_r <= '0;
         done_r    <= 1'b0;
      end else begin
         state    <= state_next;
         done_r   <= (state == MUL_RESTORE);
         // SHH needs to know whether the carry flag holds an add carry-out
         from_add <= (state == MUL_ADD);
         case (state)
            MUL_IDLE: begin
               if (start) begin
                  mcand <= mul_a;
                  ph    <= '0;
                  pl    <= mul_b;
                  cnt   <= '0;
                  saved <= {alu_flag_v, alu_flag_n, alu_flag_c, alu_flag_z};
               end
            end
            MUL_ADD:     ph <= alu_result;
            MUL_SHH:     ph <= alu_result;
            MUL_SHL: begin
               pl  <= alu_result;
               cnt <= cnt + 1'b1;
            end
            MUL_RESTORE: product_r <= {ph, pl};
            default: ;
         endcase
      end
   end

   // Next-state decode and ALU control for the current step
   always_comb begin
      state_next    = state;
      busy          = 1'b1;
      alu_op_type   = ALU_MOVE;
      alu_arith_sel = 2'b00;
      alu_logic_sel = LOGIC_AND;
      alu_shift_sel = 4'b0000;
      alu_operand1  = '0;
      alu_operand2  = '0;
      alu_flag_din  = 4'b0000;
      alu_flag_wr   = 1'b0;
      case (state)
         MUL_IDLE: begin
            busy = 1'b0;
            if (start) state_next = mul_b[0] ? MUL_ADD : MUL_SHH;
         end
         MUL_ADD: begin
            alu_op_type   = ALU_ARITH;
            alu_arith_sel = 2'b00;
            alu_operand1  = ph;
            alu_operand2  = mcand;
            state_next    = MUL_SHH;
         end
         MUL_SHH: begin
            // Rotate the add carry into PH[7], or shift in zero if no add ran
            alu_op_type   = ALU_SHIFT;
            alu_shift_sel = from_add ? {1'b0, 1'b1, SHIFT_ROR} : {2'b00, SHIFT_SHR};
            alu_operand1  = ph;
            state_next    = MUL_SHL;
         end
         MUL_SHL: begin
            // Carry holds the bit shifted out of PH; it becomes PL[7]
            alu_op_type   = ALU_SHIFT;
            alu_shift_sel = {2'b01, SHIFT_ROR};
            alu_operand1  = pl;
            if (cnt == CNT_LAST)   state_next = MUL_RESTORE;
            else if (alu_result[0]) state_next = MUL_ADD;
            else                   state_next = MUL_SHH;
         end
         MUL_RESTORE: begin
            alu_op_type  = ALU_MOVE;
            alu_flag_wr  = 1'b1;
            alu_flag_din = saved;
            state_next   = MUL_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = MUL_IDLE;
         end
      endcase
   end

endmodule
